// File: rtl/cnn_perf_monitor.sv
// Run-level performance monitor for a streaming CNN core: measures first/last
// output latency, output count, largest inter-valid gap, with timeout and overflow flags.
module cnn_perf_monitor #(
    parameter int EXP_COUNT = 4096,
    parameter int CNT_W     = 16,
    parameter int LAT_W     = 21,
    parameter int TIMEOUT   = 1048575
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic [LAT_W-1:0] first_lat_o,
    output logic [LAT_W-1:0] total_lat_o,
    output logic [CNT_W-1:0] max_gap_o,
    output logic             overflow_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN, DONE} state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] gap_cnt;

    logic [LAT_W-1:0] lat_next;
    logic [CNT_W-1:0] gap_next;
    logic [CNT_W-1:0] cnt_next;
    logic             complete;
    logic             expired;

    // lat_next is the latency of a valid sampled on the coming edge.
    always_comb begin
        lat_next = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_W'(1);
        gap_next = (&gap_cnt) ? gap_cnt : gap_cnt + CNT_W'(1);
        cnt_next = out_cnt_o + CNT_W'(1);
        complete = valid_i && (cnt_next == CNT_W'(EXP_COUNT));
        expired  = (lat_next == LAT_W'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            gap_cnt     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            out_cnt_o   <= '0;
            first_lat_o <= '0;
            total_lat_o <= '0;
            max_gap_o   <= '0;
            overflow_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= WAIT_FIRST;
                        busy_o      <= 1'b1;
                        lat_cnt     <= '0;
                        gap_cnt     <= '0;
                        out_cnt_o   <= '0;
                        first_lat_o <= '0;
                        total_lat_o <= '0;
                        max_gap_o   <= '0;
                        overflow_o  <= 1'b0;
                        timeout_o   <= 1'b0;
                    end else if (state == DONE && valid_i) begin
                        overflow_o <= 1'b1;
                    end
                end
                WAIT_FIRST, RUN: begin
                    lat_cnt <= lat_next;
                    if (valid_i) begin
                        out_cnt_o <= cnt_next;
                        gap_cnt   <= '0;
                        if (state == WAIT_FIRST)
                            first_lat_o <= lat_next;
                        else if (gap_cnt > max_gap_o)
                            max_gap_o <= gap_cnt;
                    end else begin
                        gap_cnt <= gap_next;
                    end
                    // Completion takes priority over a timeout on the same edge.
                    if (complete) begin
                        state       <= DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        total_lat_o <= lat_next;
                    end else if (expired) begin
                        state       <= DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        timeout_o   <= 1'b1;
                        total_lat_o <= LAT_W'(TIMEOUT);
                    end else if (valid_i) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_perf_monitor.sv
// Bench for cnn_perf_monitor: three instances (EXP/TIMEOUT = 8/20, 4/1000, 1/6)
// driven from a run table with a done-triggered scoreboard, plus corner-case sequences.
module tb_cnn_perf_monitor;

    localparam int CW = 16;
    localparam int LW = 21;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [CW-1:0] out_cnt;
        logic [LW-1:0] first_lat;
        logic [LW-1:0] total_lat;
        logic [CW-1:0] max_gap;
        logic          overflow;
        logic          timeout;
    } obs_t;

    typedef struct {
        int          d;
        logic [31:0] mask;
        int          done_edge;
        int          first_lat;
        int          total_lat;
        int          out_cnt;
        int          max_gap;
        int          tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] valid;
    obs_t       obs [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic          busy, done, overflow, timeout;
        logic [CW-1:0] out_cnt, max_gap;
        logic [LW-1:0] first_lat, total_lat;

        cnn_perf_monitor #(
            .EXP_COUNT((g == 0) ? 8 : (g == 1) ? 4 : 1),
            .CNT_W(CW),
            .LAT_W(LW),
            .TIMEOUT((g == 0) ? 20 : (g == 1) ? 1000 : 6)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .start_i(start[g]),
            .valid_i(valid[g]),
            .busy_o(busy),
            .done_o(done),
            .out_cnt_o(out_cnt),
            .first_lat_o(first_lat),
            .total_lat_o(total_lat),
            .max_gap_o(max_gap),
            .overflow_o(overflow),
            .timeout_o(timeout)
        );

        assign obs[g] = '{busy, done, out_cnt, first_lat, total_lat, max_gap, overflow, timeout};
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [8];
    vec_t sb [$];

    initial begin
        vec_t e;
        int   d;
        int   ndone;

        //         dut mask          edge first total cnt gap tmo
        vecs[0] = '{0, 32'h0000_1FE0, 12, 5,  12,   8,  0,  0};
        vecs[1] = '{0, 32'h0000_000E, 20, 1,  20,   3,  0,  1};
        vecs[2] = '{0, 32'h0000_7C4A, 14, 1,  14,   8,  3,  0};
        vecs[3] = '{0, 32'h0000_0000, 20, 0,  20,   0,  0,  1};
        vecs[4] = '{1, 32'h0000_018C,  8, 2,   8,   4,  3,  0};
        vecs[5] = '{2, 32'h0000_0040,  6, 6,   6,   1,  0,  0};
        vecs[6] = '{2, 32'h0000_0008,  3, 3,   3,   1,  0,  0};
        vecs[7] = '{2, 32'h0000_0000,  6, 0,   6,   0,  0,  1};

        rst   = 1'b1;
        start = '0;
        valid = '0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",      obs[i].busy,      0);
            chk("rst_done",      obs[i].done,      0);
            chk("rst_out_cnt",   obs[i].out_cnt,   0);
            chk("rst_first_lat", obs[i].first_lat, 0);
            chk("rst_total_lat", obs[i].total_lat, 0);
            chk("rst_max_gap",   obs[i].max_gap,   0);
            chk("rst_overflow",  obs[i].overflow,  0);
            chk("rst_timeout",   obs[i].timeout,   0);
        end
        rst = 1'b0;
        tick();
        chk("idle_after_rst_busy", obs[0].busy, 0);

        for (int i = 0; i < 8; i++) begin
            d = vecs[i].d;
            start[d] = 1'b1;
            tick();
            start[d] = 1'b0;
            sb.push_back(vecs[i]);
            chk("run_busy", obs[d].busy, 1);
            ndone = 0;
            for (int k = 1; k <= 31; k++) begin
                valid[d] = vecs[i].mask[k];
                tick();
                valid[d] = 1'b0;
                if (obs[d].done) begin
                    ndone++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("done_edge", k,                  e.done_edge);
                        chk("first_lat", obs[d].first_lat,   e.first_lat);
                        chk("total_lat", obs[d].total_lat,   e.total_lat);
                        chk("out_cnt",   obs[d].out_cnt,     e.out_cnt);
                        chk("max_gap",   obs[d].max_gap,     e.max_gap);
                        chk("timeout",   obs[d].timeout,     e.tmo);
                        chk("overflow",  obs[d].overflow,    0);
                        chk("busy_done", obs[d].busy,        0);
                    end
                end
            end
            chk("done_pulses", ndone, 1);
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL run_no_done: vector %0d got no done expected done", i);
                sb.delete();
            end
        end

        // Extra valid after completion, then start colliding with a valid.
        valid[1] = 1'b1;
        tick();
        valid[1] = 1'b0;
        chk("ovf_set",      obs[1].overflow, 1);
        chk("ovf_out_cnt",  obs[1].out_cnt,  4);
        chk("ovf_no_done",  obs[1].done,     0);
        start[1] = 1'b1;
        valid[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        valid[1] = 1'b0;
        chk("restart_ovf_clr", obs[1].overflow, 0);
        chk("restart_busy",    obs[1].busy,     1);
        chk("restart_cnt",     obs[1].out_cnt,  0);

        // Mid-run reset, with a stray start during RUN that must be ignored.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            valid[0] = 1'b1;
            start[0] = (k == 3);
            tick();
        end
        valid[0] = 1'b0;
        start[0] = 1'b0;
        chk("mid_cnt",       obs[0].out_cnt,   5);
        chk("mid_first_lat", obs[0].first_lat, 1);
        chk("mid_busy",      obs[0].busy,      1);
        rst      = 1'b1;
        start[0] = 1'b1;
        valid[0] = 1'b1;
        tick();
        rst      = 1'b0;
        start[0] = 1'b0;
        chk("mrst_cnt",       obs[0].out_cnt,   0);
        chk("mrst_first_lat", obs[0].first_lat, 0);
        chk("mrst_busy",      obs[0].busy,      0);
        chk("mrst_b_busy",    obs[1].busy,      0);
        tick();
        tick();
        valid[0] = 1'b0;
        chk("idle_valid_cnt",  obs[0].out_cnt,  0);
        chk("idle_valid_busy", obs[0].busy,     0);
        chk("idle_valid_ovf",  obs[0].overflow, 0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        chk("post_rst_first_lat", obs[0].first_lat, 1);
        chk("post_rst_cnt",       obs[0].out_cnt,   1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_perf_monitor.md
CNN_PERF_MONITOR -- requirements
Module: cnn_perf_monitor

Interface
REQ-001 The block SHALL have parameter EXP_COUNT, default 4096: number of valid outputs that completes one run (>=1).
REQ-002 The block SHALL have parameter CNT_W, default 16: width of output and gap counters (2^CNT_W > EXP_COUNT).
REQ-003 The block SHALL have parameter LAT_W, default 21: width of latency counters.
REQ-004 The block SHALL have parameter TIMEOUT, default 1048575: cycle budget per run (1 <= TIMEOUT < 2^LAT_W-1).
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start_i, input, 1: run-start pulse (image_ready equivalent).
REQ-008 Port valid_i, input, 1: DUT output-valid strobe (cnn_valid equivalent).
REQ-009 Port busy_o, output, 1: high in WAIT_FIRST or RUN.
REQ-010 Port done_o, output, 1: one-cycle pulse on run completion or timeout.
REQ-011 Port out_cnt_o, output, CNT_W: valid samples counted this run.
REQ-012 Port first_lat_o, output, LAT_W: start-to-first-valid latency.
REQ-013 Port total_lat_o, output, LAT_W: start-to-last-valid latency.
REQ-014 Port max_gap_o, output, CNT_W: largest idle-cycle gap between consecutive valids.
REQ-015 Port overflow_o, output, 1: sticky; valid seen after completion.
REQ-016 Port timeout_o, output, 1: sticky; run ended by TIMEOUT.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_FIRST, RUN, DONE; all outputs registered.
REQ-018 start_i sampled in IDLE or DONE SHALL clear all counters and sticky flags and enter WAIT_FIRST next cycle; start_i in WAIT_FIRST/RUN SHALL be ignored.
REQ-019 Internal lat_cnt SHALL be 0 at start and increment by 1 every cycle in WAIT_FIRST/RUN, saturating at all-ones.
REQ-020 Latency of a valid sampled at edge k after the start edge (edge 0) SHALL be k, i.e. lat_cnt+1 at sampling.
REQ-021 valid_i in WAIT_FIRST SHALL set first_lat_o = latency, out_cnt_o = 1, enter RUN (or DONE if EXP_COUNT = 1).
REQ-022 valid_i in RUN SHALL increment out_cnt_o; gap = idle cycles since previous valid (back-to-back = 0); max_gap_o = max(max_gap_o, gap), gap counter saturating.
REQ-023 The valid that makes out_cnt_o = EXP_COUNT SHALL set total_lat_o = latency, enter DONE, pulse done_o for exactly one cycle.
REQ-024 If lat_cnt+1 reaches TIMEOUT in WAIT_FIRST/RUN without completion, block SHALL set timeout_o, pulse done_o, enter DONE; total_lat_o = TIMEOUT, out_cnt_o holds partial count.
REQ-025 Completing valid and timeout in same cycle: completion SHALL win; timeout_o stays 0.
REQ-026 valid_i in DONE SHALL set overflow_o (sticky) and leave out_cnt_o unchanged; valid_i in IDLE SHALL be ignored.
REQ-027 start_i and valid_i in same DONE cycle: start SHALL win; valid dropped, overflow_o cleared.
REQ-028 Results SHALL hold in DONE until next start_i or rst.

Reset
REQ-029 rst high at a rising edge SHALL force IDLE and all outputs to 0, including mid-run; rst SHALL override start_i.
REQ-030 After rst release, block SHALL stay IDLE until start_i.

Verification
REQ-031 EXP_COUNT=8; start edge 0; valid edges 5..12 -> first_lat 5, total_lat 12, out_cnt 8, max_gap 0, done_o pulse cycle after edge 12.
REQ-032 EXP_COUNT=4; valids at edges 2,3,7,8 -> max_gap 3, total_lat 8, overflow 0.
REQ-033 EXP_COUNT=4, completed; one extra valid -> overflow_o 1, out_cnt 4; next start_i -> overflow_o 0, state WAIT_FIRST.
REQ-034 TIMEOUT=20, EXP_COUNT=8; 3 valids then none -> timeout_o 1 at edge 20, out_cnt 3, total_lat 20, single done_o pulse.
REQ-035 rst asserted mid-RUN with out_cnt 5 -> all outputs 0, busy_o 0; valid_i then ignored until start_i.
REQ-036 EXP_COUNT=1, TIMEOUT=6; valid at edge 6 -> completion wins: done, timeout_o 0, total_lat 6.
